// File: rtl/fma16_issue_ctrl_if.sv
// Command/result handshake bundle for fma16_issue_ctrl.
//   in_*  : producer -> controller command channel (valid/ready)
//   out_* : controller -> consumer result channel (valid/ready)
// slave modport is the controller side, master modport is the producer/consumer side.
interface fma16_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] in_z;
  logic [1:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;

  modport slave (
    input  in_valid, in_op, in_x, in_y, in_z, in_rm, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

  modport master (
    output in_valid, in_op, in_x, in_y, in_z, in_rm, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fma16_issue_ctrl.sv
// fma16_issue_ctrl: command FIFO + registered result slot around a combinational
// FP16 fused multiply-add datapath, with an accumulated sticky flag register.
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : in_* command handshake, out_* result handshake
//   fflags       : sticky {nv, of, uf, nx}; fflags_clr clears it
//   busy         : FIFO non-empty or result slot full
// fma16: (-1)^negr * ((mul ? x*y : x) + (add ? (-1)^negz * z : nothing)),
// single rounding; rm 0 RNE, 1 RTZ, 2 RDN, 3 RUP; flags {nv, of, uf, nx}.

module fma16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic [1:0]  rm,
  input  logic        mul,
  input  logic        add,
  input  logic        negr,
  input  logic        negz,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  function automatic logic is_nan(input logic [15:0] a);
    return (&a[14:10]) && (|a[9:0]);
  endfunction
  function automatic logic is_snan(input logic [15:0] a);
    return is_nan(a) && !a[9];
  endfunction
  function automatic logic is_inf(input logic [15:0] a);
    return (&a[14:10]) && (a[9:0] == '0);
  endfunction
  function automatic logic is_zero(input logic [15:0] a);
    return a[14:0] == '0;
  endfunction
  function automatic logic [10:0] sig(input logic [15:0] a);
    return {|a[14:10], a[9:0]};
  endfunction
  function automatic logic [6:0] bexp(input logic [15:0] a);
    return (a[14:10] == '0) ? 7'd1 : {2'b0, a[14:10]};
  endfunction

  logic [15:0] ye;
  logic        sp, sz, rs, zs, pinf, zinf, nan_in, inv;
  logic [21:0] prod;
  logic [79:0] pm, zm;
  logic [80:0] mag;
  logic [6:0]  lead, lsb;
  logic [12:0] t;
  logic        sticky, g, inc, inexact, tiny, ovf_inf;
  logic [11:0] rnd;
  logic [16:0] enc;

  assign ye = mul ? y : 16'h3C00;

  // Both terms are placed exactly on a fixed-point grid with LSB 2^-48, so the
  // sum is exact and rounding happens once.
  always_comb begin
    sp     = x[15] ^ ye[15] ^ negr;
    sz     = z[15] ^ negz ^ negr;
    pinf   = is_inf(x) | is_inf(ye);
    zinf   = add & is_inf(z);
    nan_in = is_nan(x) | is_nan(ye) | (add & is_nan(z));
    inv    = is_snan(x) | is_snan(ye) | (add & is_snan(z)) |
             (is_inf(x) & is_zero(ye)) | (is_zero(x) & is_inf(ye)) |
             (pinf & zinf & (sp != sz) & ~is_nan(x) & ~is_nan(ye));
    prod   = sig(x) * sig(ye);
    pm     = {58'b0, prod} << (bexp(x) + bexp(ye) - 7'd2);
    zm     = add ? ({69'b0, sig(z)} << (bexp(z) + 7'd23)) : '0;
    if (sp == sz) begin
      mag = {1'b0, pm} + {1'b0, zm};
      rs  = sp;
    end else if (pm >= zm) begin
      mag = {1'b0, pm - zm};
      rs  = sp;
    end else begin
      mag = {1'b0, zm - pm};
      rs  = sz;
    end
    lead = '0;
    for (int unsigned i = 0; i < 81; i++) begin
      if (mag[i]) lead = 7'(i);
    end
    tiny    = lead < 7'd34;
    lsb     = tiny ? 7'd24 : lead - 7'd10;
    t       = 13'(mag >> (lsb - 7'd2));
    sticky  = t[0] | ((mag & ((81'd1 << (lsb - 7'd2)) - 81'd1)) != '0);
    g       = t[1];
    inexact = g | sticky;
    case (rm)
      2'd0:    inc = g & (sticky | t[2]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = rs & inexact;
      default: inc = ~rs & inexact;
    endcase
    rnd = {1'b0, t[12:2]} + {11'b0, inc};
    // Hidden bit of rnd adds one to the exponent field, so a rounding carry
    // (subnormal->normal or mantissa overflow) propagates naturally.
    enc = {(tiny ? 7'd0 : lead - 7'd34), 10'b0} + {5'b0, rnd};
    zs  = ~add ? sp : ((sp == sz) ? sp : (rm == 2'd2));
    ovf_inf = (rm == 2'd0) | ((rm == 2'd2) & rs) | ((rm == 2'd3) & ~rs);

    result = '0;
    flags  = '0;
    if (nan_in | inv) begin
      result = 16'h7E00;
      flags  = {inv, 3'b000};
    end else if (pinf) begin
      result = {sp, 15'h7C00};
    end else if (zinf) begin
      result = {sz, 15'h7C00};
    end else if (mag == '0) begin
      result = {zs, 15'h0000};
    end else if (enc >= 17'h07C00) begin
      result = {rs, ovf_inf ? 15'h7C00 : 15'h7BFF};
      flags  = 4'b0101;
    end else begin
      result = {rs, enc[14:0]};
      flags  = {2'b00, tiny & inexact, inexact};
    end
  end
endmodule

module fma16_issue_ctrl #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTRW  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  fma16_issue_ctrl_if.slave     bus,
  output logic [3:0]            fflags,
  input  logic                  fflags_clr,
  output logic                  busy
);
  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [1:0]  rm;
  } cmd_t;

  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [PTRW-1:0] wptr, rptr;
  logic [PTRW:0]   count;
  logic            push, pop;
  logic            d_mul, d_add, d_negr, d_negz;
  logic [15:0]     dp_result, cap_result;
  logic [3:0]      dp_flags, cap_flags;

  assign bus.in_ready = (count != (PTRW+1)'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (count != '0) & (~bus.out_valid | bus.out_ready);
  assign busy         = (count != '0) | bus.out_valid;
  assign head         = mem[rptr];

  always_comb begin
    {d_mul, d_add, d_negr, d_negz} = 4'b0000;
    case (head.op)
      3'd0:    {d_mul, d_add, d_negr, d_negz} = 4'b1000;
      3'd1:    {d_mul, d_add, d_negr, d_negz} = 4'b0100;
      3'd2:    {d_mul, d_add, d_negr, d_negz} = 4'b0101;
      3'd3:    {d_mul, d_add, d_negr, d_negz} = 4'b1100;
      3'd4:    {d_mul, d_add, d_negr, d_negz} = 4'b1101;
      3'd5:    {d_mul, d_add, d_negr, d_negz} = 4'b1110;
      3'd6:    {d_mul, d_add, d_negr, d_negz} = 4'b1111;
      default: {d_mul, d_add, d_negr, d_negz} = 4'b0000;
    endcase
  end

  fma16 u_fma16 (
    .x      (head.x),
    .y      (head.y),
    .z      (head.z),
    .rm     (head.rm),
    .mul    (d_mul),
    .add    (d_add),
    .negr   (d_negr),
    .negz   (d_negz),
    .result (dp_result),
    .flags  (dp_flags)
  );

  assign cap_result = (head.op == 3'd7) ? 16'h7E00 : dp_result;
  assign cap_flags  = (head.op == 3'd7) ? 4'b1000  : dp_flags;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{op: bus.in_op, x: bus.in_x, y: bus.in_y, z: bus.in_z, rm: bus.in_rm};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_flags  <= '0;
      fflags         <= '0;
    end else begin
      if (push) wptr <= wptr + PTRW'(1);
      if (pop)  rptr <= rptr + PTRW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: count <= count;
      endcase
      if (pop) begin
        bus.out_valid  <= 1'b1;
        bus.out_result <= cap_result;
        bus.out_flags  <= cap_flags;
      end else if (bus.out_ready) begin
        bus.out_valid  <= 1'b0;
      end
      fflags <= (fflags_clr ? 4'b0000 : fflags) | (pop ? cap_flags : 4'b0000);
    end
  end
endmodule

// File: doc/fma16_issue_ctrl.md
Name: fma16_issue_ctrl

Overview:
- Sequential front/back-end for the combinational fma16 datapath.
- Accepts FP16 operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each opcode into the mul/add/negr/negz controls, drives one fma16 instance, and registers the result and flags into an output slot with its own valid/ready handshake.
- Keeps an accumulated sticky exception-flag register (fflags-style) for software readback.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- PTRW, $clog2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept a command.
- in_op  input  3  opcode: 0 fmul, 1 fadd, 2 fsub, 3 fmadd, 4 fmsub, 5 fnmadd, 6 fnmsub, 7 reserved.
- in_x, in_y, in_z  input  16 each  FP16 operands.
- in_rm  input  2  rounding mode, forwarded to the datapath per command.
- out_valid  output  1  result slot full.
- out_ready  input  1  consumer takes the result.
- out_result  output  16  FP16 result.
- out_flags  output  4  {nv, of, uf, nx} for this result.
- fflags  output  4  accumulated sticky flags.
- fflags_clr  input  1  clear sticky flags.
- busy  output  1  FIFO non-empty or out_valid.

Behaviour:
- Reset, synchronous, highest priority:
  - FIFO pointers and count go to 0.
  - out_valid=0, out_result=16'h0000, out_flags=0, fflags=0.
  - Commands in flight are discarded.
- in_ready = (count != DEPTH). It is registered-state only and has no combinational path from out_ready.
- Push: occurs when in_valid & in_ready.
- Pop:
  - pop = (count != 0) & (~out_valid | out_ready).
  - The FIFO head drives fma16 combinationally.
  - On pop, out_result and out_flags load from the datapath and out_valid <= 1.
  - Otherwise, out_ready & out_valid clears out_valid.
  - If the FIFO is empty and the slot drains, out_valid <= 0.
- Latency:
  - A command accepted at edge t, with FIFO previously empty and slot free, gives out_valid=1 after edge t+1.
  - Sustained throughput is 1 op/cycle while out_ready=1.
- Simultaneous push and pop:
  - Count is unchanged.
  - This is legal at count==DEPTH only if the pop occurs. in_ready is still 0 at full, so no push happens; full holds one cycle.
  - At count==0, a pushed command is not popped in the same cycle (no bypass).
- Pointer wrap-around:
  - Pointers are PTRW bits and wrap modulo DEPTH.
  - count is a separate PTRW+1-bit register.
- Opcode decode, as {mul, add, negr, negz}:
  - fmul 1000, fadd 0100, fsub 0101, fmadd 1100, fmsub 1101, fnmadd 1110, fnmsub 1111.
- Reserved opcode 7: the datapath output is ignored; the captured result is 16'h7E00 and out_flags = 4'b1000.
- Order: results leave strictly in command acceptance order.
- fflags:
  - fflags <= (fflags_clr ? 4'b0 : fflags) | (pop ? captured_flags : 4'b0).
  - A clear coincident with a capture retains the new flags.
- Output stability: out_result and out_flags hold stable while out_valid & ~out_ready.
- busy = (count != 0) | out_valid.
- Datapath control:
  - The fma16 instance is driven only from the FIFO head; operand inputs are don't-care when count==0.
  - Head operands are held stable under output stall.

Test Plan:
- Basic fmul: reset, then push op=0, x=3C00, y=4000, out_ready=1 -> out_valid one cycle after accept, out_result=4000, out_flags=0000, fflags=0000.
- fmadd: op=3, x=4000, y=4200, z=3C00 -> out_result=4700 (7.0), out_flags=0000. Then op=2 (fsub), x=4000, z=3C00 -> 3C00.
- Overflow and sticky flags: op=0, x=7BFF, y=7BFF -> out_result=7C00, out_flags=0101, fflags=0101. Then op=0, x=0000, y=7C00 -> 7E00, out_flags=1000, fflags=1101. Then pulse fflags_clr with no pop -> fflags=0000.
- Backpressure/full, DEPTH=4: hold out_ready=0 and push 6 commands -> 1 captured in slot, 4 in FIFO, in_ready=0 after the 5th accept, 6th held off. Release out_ready -> 5 results in order, then the 6th.
- Wrap and throughput: stream 20 back-to-back fadds (x = n, z = 3C00) with out_ready=1 -> in_ready stays 1, one result per cycle, values n+1 in order, no drops across pointer wrap.
- Reset mid-operation and edge cases:
  - Assert reset with 3 queued and out_valid=1 -> next cycle out_valid=0, busy=0, in_ready=1, fflags=0.
  - Push op=7 -> 7E00 with flags 1000.
  - Apply fflags_clr coincident with an nx-raising capture -> fflags=0001.
